// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern transmitter and its partner detector.
package pattern_pkg;

   // Pattern is sent MSB first: "b", "o", "m", "b".
   localparam logic [31:0] DEFAULT_PATTERN   = 32'h626F6D62;
   localparam logic [7:0]  DEFAULT_IDLE_BYTE = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_FOUND,
      ST_ACK_LOW,
      ST_ACK_HIGH
   } tx_state_e;

   // Byte idx of the pattern, idx 0 being the most significant byte.
   function automatic logic [7:0] pattern_byte(input logic [31:0] pat, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = pat[31:24];
         2'd1:    b = pat[23:16];
         2'd2:    b = pat[15:8];
         default: b = pat[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/pattern_timeout_counter.sv
// Clearable up-counter with a flag marking the last cycle of a LIMIT-cycle window.
module pattern_timeout_counter
   import pattern_pkg::*;
#(
   parameter int unsigned LIMIT = 16
) (
   input  logic                         clk,
   input  logic                         reset_sync,
   input  logic                         i_clear,
   input  logic                         i_enable,
   output logic [$clog2(LIMIT+1)-1:0]   o_count,
   output logic                         o_terminal
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] r_count;

   // Count cycles since the last clear; saturate so an idle counter never wraps.
   always_ff @(posedge clk or negedge reset_sync) begin
      if (!reset_sync) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != CW'(LIMIT))) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign o_count    = r_count;
   assign o_terminal = (r_count == CW'(LIMIT - 1));

endmodule

// File: rtl/pattern_sequence_tx.sv
// Transmit side of the pattern detector link: sends the 4-byte pattern,
// waits for found_pattern, runs the ack-low/ack-high release and reports.
//
// state         | meaning
// --------------+---------------------------------------------------------
// ST_IDLE       | data=IDLE_BYTE, ack=1, waiting for start
// ST_SEND       | one pattern byte per cycle, byte_idx 0..3
// ST_WAIT_FOUND | waiting up to TIMEOUT cycles for found_pattern=1
// ST_ACK_LOW    | ack held low for ACK_LOW_CYCLES cycles
// ST_ACK_HIGH   | ack high, waiting up to TIMEOUT cycles for found_pattern=0
module pattern_sequence_tx
   import pattern_pkg::*;
#(
   parameter logic [31:0] PATTERN        = DEFAULT_PATTERN,
   parameter logic [7:0]  IDLE_BYTE      = DEFAULT_IDLE_BYTE,
   parameter int unsigned ACK_LOW_CYCLES = 2,
   parameter int unsigned TIMEOUT        = 16,
   parameter int unsigned MAX_RETRIES    = 2
) (
   input  logic       clk,
   input  logic       reset_sync,
   input  logic       start,
   input  logic       found_pattern,
   output logic [7:0] data,
   output logic       ack,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] retries_used
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   tx_state_e  r_state;
   tx_state_e  w_next_state;
   logic [1:0] r_byte_idx;
   logic [1:0] w_next_idx;
   logic [1:0] r_retries;
   logic [1:0] w_next_retries;
   logic [7:0] r_data;
   logic       r_ack;
   logic       r_done;
   logic       r_error;
   logic       w_done_set;
   logic       w_error_set;
   logic       w_cnt_clear;
   logic       w_terminal;
   logic [CNT_W-1:0] w_count;

   // One counter serves every timed state; it restarts on each state change.
   assign w_cnt_clear = (w_next_state != r_state);

   pattern_timeout_counter #(
      .LIMIT (TIMEOUT)
   ) u_timeout (
      .clk        (clk),
      .reset_sync (reset_sync),
      .i_clear    (w_cnt_clear),
      .i_enable   (1'b1),
      .o_count    (w_count),
      .o_terminal (w_terminal)
   );

   // Next-state, byte index, retry bookkeeping and completion strobes.
   always_comb begin
      w_next_state   = r_state;
      w_next_idx     = r_byte_idx;
      w_next_retries = r_retries;
      w_done_set     = 1'b0;
      w_error_set    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next_state   = ST_SEND;
               w_next_idx     = 2'd0;
               w_next_retries = 2'd0;
            end
         end
         ST_SEND: begin
            if (r_byte_idx == 2'd3) begin
               w_next_state = ST_WAIT_FOUND;
            end else begin
               w_next_idx = r_byte_idx + 2'd1;
            end
         end
         ST_WAIT_FOUND: begin
            if (found_pattern) begin
               w_next_state = ST_ACK_LOW;
            end else if (w_terminal) begin
               if (r_retries < 2'(MAX_RETRIES)) begin
                  w_next_retries = r_retries + 2'd1;
                  w_next_idx     = 2'd0;
                  w_next_state   = ST_SEND;
               end else begin
                  w_error_set  = 1'b1;
                  w_next_state = ST_IDLE;
               end
            end
         end
         ST_ACK_LOW: begin
            if (w_count == CNT_W'(ACK_LOW_CYCLES - 1)) begin
               w_next_state = ST_ACK_HIGH;
            end
         end
         ST_ACK_HIGH: begin
            if (!found_pattern) begin
               w_done_set   = 1'b1;
               w_next_state = ST_IDLE;
            end else if (w_terminal) begin
               w_error_set  = 1'b1;
               w_next_state = ST_IDLE;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // State and outputs; data/ack are decoded from the next state so they line up with it.
   always_ff @(posedge clk or negedge reset_sync) begin
      if (!reset_sync) begin
         r_state    <= ST_IDLE;
         r_byte_idx <= 2'd0;
         r_retries  <= 2'd0;
         r_data     <= IDLE_BYTE;
         r_ack      <= 1'b1;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_byte_idx <= w_next_idx;
         r_retries  <= w_next_retries;
         r_data     <= (w_next_state == ST_SEND) ? pattern_byte(PATTERN, w_next_idx) : IDLE_BYTE;
         r_ack      <= (w_next_state != ST_ACK_LOW);
         r_done     <= w_done_set;
         r_error    <= w_error_set;
      end
   end

   assign data         = r_data;
   assign ack          = r_ack;
   assign busy         = (r_state != ST_IDLE);
   assign done         = r_done;
   assign error        = r_error;
   assign retries_used = r_retries;

endmodule
